// File: rtl/fuzzifier_seq.sv
// rtl/fuzzifier_seq.sv - time-multiplexed N_MF trapezoidal fuzzifier, one MF per cycle
module fuzzifier_seq #(
   parameter int N_MF  = 5,
   parameter int X_W   = 8,
   parameter int MU_W  = 16,
   parameter int IDX_W = $clog2(N_MF)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic signed [X_W-1:0] x,
   input  logic                  cfg_we,
   input  logic [IDX_W-1:0]      cfg_idx,
   input  logic [2:0]            cfg_sel,
   input  logic [15:0]           cfg_data,
   output logic                  cfg_err,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [N_MF*MU_W-1:0]  mu_vec,
   output logic [IDX_W-1:0]      max_idx
);
   localparam int P_W = X_W + 17;
   localparam logic [MU_W-1:0] MU_MAX = MU_W'(32767);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   state_t state;

   logic signed [X_W-1:0] cfg_a [N_MF];
   logic signed [X_W-1:0] cfg_b [N_MF];
   logic signed [X_W-1:0] cfg_c [N_MF];
   logic signed [X_W-1:0] cfg_d [N_MF];
   logic [15:0]           cfg_il [N_MF];
   logic [15:0]           cfg_ir [N_MF];

   logic signed [X_W-1:0] x_l;
   logic [IDX_W-1:0]      idx, best_idx;
   logic [MU_W-1:0]       best_mu, mu_cur;

   // A write arriving with the sample handshake is parked so the sample sees the old config
   logic                  pend_v;
   logic [IDX_W-1:0]      pend_idx;
   logic [2:0]            pend_sel;
   logic [15:0]           pend_data;

   logic                  hs, we_ok, we_bad, wr_en;
   logic [IDX_W-1:0]      wr_idx;
   logic [2:0]            wr_sel;
   logic [15:0]           wr_data;

   assign hs     = in_valid && in_ready;
   assign we_ok  = cfg_we && (state == IDLE) && (int'(cfg_idx) < N_MF);
   assign we_bad = cfg_we && !we_ok;

   always_comb begin
      wr_en   = 1'b0;
      wr_idx  = cfg_idx;
      wr_sel  = cfg_sel;
      wr_data = cfg_data;
      if (pend_v && (state == DONE) && out_ready) begin
         wr_en   = 1'b1;
         wr_idx  = pend_idx;
         wr_sel  = pend_sel;
         wr_data = pend_data;
      end else if (we_ok && !hs) begin
         wr_en = 1'b1;
      end
   end

   logic signed [X_W:0] xw, aw, bw, cw, dw;
   logic [X_W:0]        dl, dr;
   logic [P_W-1:0]      pl, pr;

   assign xw = {x_l[X_W-1], x_l};
   assign aw = {cfg_a[idx][X_W-1], cfg_a[idx]};
   assign bw = {cfg_b[idx][X_W-1], cfg_b[idx]};
   assign cw = {cfg_c[idx][X_W-1], cfg_c[idx]};
   assign dw = {cfg_d[idx][X_W-1], cfg_d[idx]};
   assign dl = xw - aw;
   assign dr = dw - xw;
   assign pl = P_W'(dl) * P_W'(cfg_il[idx]);
   assign pr = P_W'(dr) * P_W'(cfg_ir[idx]);

   function automatic logic [MU_W-1:0] sat(input logic [P_W-1:0] p);
      return (p > P_W'(32767)) ? MU_MAX : MU_W'(p);
   endfunction

   // Region order matters: x>d beats the plateau when c>d is misconfigured
   always_comb begin
      mu_cur = '0;
      if (xw < aw || xw > dw) mu_cur = '0;
      else if (xw < bw)       mu_cur = sat(pl);
      else if (xw <= cw)      mu_cur = MU_MAX;
      else                    mu_cur = sat(pr);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         cfg_err   <= 1'b0;
         mu_vec    <= '0;
         max_idx   <= '0;
         x_l       <= '0;
         idx       <= '0;
         best_idx  <= '0;
         best_mu   <= '0;
         pend_v    <= 1'b0;
         pend_idx  <= '0;
         pend_sel  <= '0;
         pend_data <= '0;
         for (int i = 0; i < N_MF; i++) begin
            cfg_a[i]  <= '0;
            cfg_b[i]  <= '0;
            cfg_c[i]  <= '0;
            cfg_d[i]  <= '0;
            cfg_il[i] <= '0;
            cfg_ir[i] <= '0;
         end
      end else begin
         cfg_err <= we_bad;
         if (wr_en) begin
            case (wr_sel)
               3'd0:    cfg_a[wr_idx]  <= wr_data[X_W-1:0];
               3'd1:    cfg_b[wr_idx]  <= wr_data[X_W-1:0];
               3'd2:    cfg_c[wr_idx]  <= wr_data[X_W-1:0];
               3'd3:    cfg_d[wr_idx]  <= wr_data[X_W-1:0];
               3'd4:    cfg_il[wr_idx] <= wr_data;
               3'd5:    cfg_ir[wr_idx] <= wr_data;
               default: ;
            endcase
         end
         if (we_ok && hs) begin
            pend_v    <= 1'b1;
            pend_idx  <= cfg_idx;
            pend_sel  <= cfg_sel;
            pend_data <= cfg_data;
         end else if ((state == DONE) && out_ready) begin
            pend_v <= 1'b0;
         end
         case (state)
            IDLE: if (hs) begin
               x_l      <= x;
               idx      <= '0;
               best_mu  <= '0;
               best_idx <= '0;
               in_ready <= 1'b0;
               state    <= CALC;
            end
            CALC: begin
               mu_vec[int'(idx)*MU_W +: MU_W] <= mu_cur;
               if (mu_cur > best_mu) begin
                  best_mu  <= mu_cur;
                  best_idx <= idx;
               end
               if (int'(idx) == N_MF - 1) begin
                  max_idx   <= (mu_cur > best_mu) ? idx : best_idx;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            DONE: if (out_ready) begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fuzzifier_seq.sv
// tb/tb_fuzzifier_seq.sv - scoreboard bench for fuzzifier_seq
module tb_fuzzifier_seq;
   localparam int N_MF = 5, X_W = 8, MU_W = 16, IDX_W = 3, VW = N_MF * MU_W;

   logic                  clk = 1'b0, rst_n = 1'b0;
   logic                  in_valid = 1'b0, in_ready;
   logic signed [X_W-1:0] x = '0;
   logic                  cfg_we = 1'b0, cfg_err;
   logic [IDX_W-1:0]      cfg_idx = '0;
   logic [2:0]            cfg_sel = '0;
   logic [15:0]           cfg_data = '0;
   logic                  out_valid, out_ready = 1'b1;
   logic [VW-1:0]         mu_vec, held;
   logic [IDX_W-1:0]      max_idx;

   int errors = 0, checks = 0, lat;

   typedef struct {
      logic [VW-1:0]    mu;
      logic [IDX_W-1:0] idx;
   } exp_t;
   exp_t sb[$];
   exp_t mon_e;

   int ma[N_MF], mb[N_MF], mc[N_MF], md[N_MF], mil[N_MF], mir[N_MF];
   int sx[5] = '{-100, -30, -10, 1, -127};
   int sm[5] = '{0, 32767, 16380, 0, 0};

   fuzzifier_seq #(.N_MF(N_MF), .X_W(X_W), .MU_W(MU_W), .IDX_W(IDX_W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .x(x),
      .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
      .cfg_err(cfg_err), .out_valid(out_valid), .out_ready(out_ready),
      .mu_vec(mu_vec), .max_idx(max_idx)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic int mf_model(int xi, int i);
      int p;
      if (xi < ma[i] || xi > md[i]) return 0;
      if (xi < mb[i]) begin
         p = (xi - ma[i]) * mil[i];
         return (p > 32767) ? 32767 : p;
      end
      if (xi <= mc[i]) return 32767;
      p = (md[i] - xi) * mir[i];
      return (p > 32767) ? 32767 : p;
   endfunction

   function automatic exp_t expect_for(int xi);
      exp_t e;
      int v, best;
      e.mu = '0;
      e.idx = '0;
      best = 0;
      for (int i = 0; i < N_MF; i++) begin
         v = mf_model(xi, i);
         e.mu[i*MU_W +: MU_W] = MU_W'(v);
         if (v > best) begin
            best = v;
            e.idx = IDX_W'(i);
         end
      end
      return e;
   endfunction

   function automatic int mu_at(int i);
      return int'(mu_vec[i*MU_W +: MU_W]);
   endfunction

   task automatic model_set(int i, int sel, int val);
      logic signed [7:0] t;
      t = val[7:0];
      case (sel)
         0: ma[i] = t;
         1: mb[i] = t;
         2: mc[i] = t;
         3: md[i] = t;
         4: mil[i] = val & 16'hffff;
         5: mir[i] = val & 16'hffff;
         default: ;
      endcase
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic cfg_write(int i, int sel, int val, bit exp_err);
      cfg_we = 1'b1; cfg_idx = IDX_W'(i); cfg_sel = 3'(sel); cfg_data = 16'(val);
      tick;
      cfg_we = 1'b0;
      check("cfg_err", cfg_err, exp_err);
      if (!exp_err) model_set(i, sel, val);
   endtask

   task automatic send(int xi);
      int n = 0;
      in_valid = 1'b1;
      x = X_W'(xi);
      while (!in_ready && n < 50) begin tick; n++; end
      if (n >= 50) check("in_ready_timeout", 0, 1);
      tick;
      in_valid = 1'b0;
      sb.push_back(expect_for(xi));
   endtask

   task automatic wait_out(output int l);
      l = 0;
      while (!out_valid && l < 50) begin tick; l++; end
      check("out_valid_timeout", out_valid, 1);
   endtask

   task automatic consume;
      out_ready = 1'b1;
      tick;
      check("post_out_valid", out_valid, 0);
      check("post_in_ready", in_ready, 1);
   endtask

   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (sb.size() == 0) check("sb_unexpected", 1, 0);
         else begin
            mon_e = sb.pop_front();
            check("mu_vec", mu_vec, mon_e.mu);
            check("max_idx", max_idx, mon_e.idx);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1);
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_cfg_err", cfg_err, 0);
      check("rst_mu_vec", mu_vec, 0);
      check("rst_max_idx", max_idx, 0);
      rst_n = 1'b1;
      tick;

      cfg_write(0, 0, -100, 0); cfg_write(0, 1, -50, 0); cfg_write(0, 2, -20, 0);
      cfg_write(0, 3, 0, 0);    cfg_write(0, 4, 655, 0); cfg_write(0, 5, 1638, 0);
      send(-75);
      wait_out(lat);
      check("latency", lat, N_MF);
      check("rise_mu0", mu_at(0), 16375);
      check("rise_idx", max_idx, 0);
      consume;

      for (int k = 0; k < 5; k++) begin
         send(sx[k]);
         wait_out(lat);
         check("sweep_mu0", mu_at(0), sm[k]);
         consume;
      end

      cfg_write(1, 0, 0, 0); cfg_write(1, 1, 0, 0); cfg_write(1, 2, 10, 0);
      cfg_write(1, 3, 20, 0); cfg_write(1, 5, 65535, 0);
      send(19); wait_out(lat); check("sat_mu1", mu_at(1), 32767); consume;
      send(0);  wait_out(lat); check("shoulder_mu1", mu_at(1), 32767); consume;
      cfg_write(1, 3, 10, 0);
      send(11); wait_out(lat); check("cd_equal_mu1", mu_at(1), 0); consume;

      cfg_write(3, 2, 10, 0); cfg_write(3, 3, 10, 0);
      send(5); wait_out(lat);
      check("tie_mu3", mu_at(3), 32767);
      check("tie_idx", max_idx, 1);
      consume;

      out_ready = 1'b0;
      send(-75);
      wait_out(lat);
      held = mu_vec;
      in_valid = 1'b1;
      x = 8'sd5;
      for (int k = 0; k < 10; k++) begin
         tick;
         check("bp_out_valid", out_valid, 1);
         check("bp_in_ready", in_ready, 0);
         check("bp_mu_hold", mu_vec, held);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick;
      check("bp_idle_in_ready", in_ready, 1);
      check("bp_idle_out_valid", out_valid, 0);
      repeat (N_MF + 2) tick;
      check("bp_no_accept", out_valid, 0);
      check("bp_sb_empty", sb.size(), 0);

      send(-10);
      cfg_we = 1'b1; cfg_idx = 3'd0; cfg_sel = 3'd3; cfg_data = 16'd10;
      tick;
      cfg_we = 1'b0;
      check("calc_err_hi", cfg_err, 1);
      tick;
      check("calc_err_lo", cfg_err, 0);
      wait_out(lat);
      check("calc_mu0", mu_at(0), 16380);
      consume;

      cfg_write(7, 0, 5, 1);
      tick;
      check("idx7_err_lo", cfg_err, 0);

      cfg_we = 1'b1; cfg_idx = 3'd0; cfg_sel = 3'd4; cfg_data = 16'd1000;
      in_valid = 1'b1; x = -8'sd75;
      tick;
      cfg_we = 1'b0; in_valid = 1'b0;
      sb.push_back(expect_for(-75));
      model_set(0, 4, 1000);
      check("same_err", cfg_err, 0);
      wait_out(lat); check("same_old", mu_at(0), 16375); consume;
      send(-75); wait_out(lat); check("same_new", mu_at(0), 25000); consume;

      send(-75);
      tick;
      tick;
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", out_valid, 0);
      check("midrst_in_ready", in_ready, 1);
      check("midrst_mu_vec", mu_vec, 0);
      sb.delete();
      for (int i = 0; i < N_MF; i++) begin
         ma[i] = 0; mb[i] = 0; mc[i] = 0; md[i] = 0; mil[i] = 0; mir[i] = 0;
      end
      tick;
      rst_n = 1'b1;
      tick;
      send(0);
      wait_out(lat);
      check("cleared_mu_all", mu_vec, {5{16'h7fff}});
      check("cleared_idx", max_idx, 0);
      consume;

      check("sb_drained", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
